// File: rtl/digit_acc_sched_pkg.sv
// Shared types and constants for the round-robin decimal accumulator scheduler.
package digit_acc_sched_pkg;

    localparam int unsigned DIGIT_MAX = 9;
    localparam int unsigned BCD_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/digit_acc_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins, wrapping to 0.
module digit_acc_sched_rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    // Wrapped requesters (below ptr) are picked first, then overridden by any at/above ptr.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (IDX_W'(i) < ptr)) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (IDX_W'(i) >= ptr)) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/digit_acc_sched.sv
// Shares one two-digit decimal accumulator between NUM_REQ requesters, one op at a time.
module digit_acc_sched
    import digit_acc_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned SETTLE  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_sel,
    input  logic [BCD_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [BCD_W-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     acc_select,
    output logic                     acc_add,
    output logic [BCD_W-1:0]         acc_data,
    input  logic [BCD_W-1:0]         acc_result
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(SETTLE + 1);

    state_t             state, state_d;
    logic [IDX_W-1:0]   ptr, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               sel_q, sel_d;
    logic [BCD_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   cnt, cnt_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   win_idx;
    logic [BCD_W-1:0]   win_data;

    logic [NUM_REQ-1:0] rsp_valid_d;
    logic [BCD_W-1:0]   rsp_data_d;
    logic               rsp_err_d;
    logic               acc_select_d;
    logic               acc_add_d;
    logic [BCD_W-1:0]   acc_data_d;

    digit_acc_sched_rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    assign win_data  = req_data[BCD_W*int'(win_idx) +: BCD_W];
    assign req_ready = (state == IDLE) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            idx_q  <= '0;
            sel_q  <= 1'b0;
            data_q <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_d;
            ptr    <= ptr_d;
            idx_q  <= idx_d;
            sel_q  <= sel_d;
            data_q <= data_d;
            cnt    <= cnt_d;
        end
    end

    // Next state plus the values every registered output takes on the following cycle.
    always_comb begin
        state_d      = state;
        ptr_d        = ptr;
        idx_d        = idx_q;
        sel_d        = sel_q;
        data_d       = data_q;
        cnt_d        = cnt;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data;
        rsp_err_d    = 1'b0;
        acc_select_d = acc_select;
        acc_add_d    = 1'b0;
        acc_data_d   = acc_data;

        case (state)
            IDLE: begin
                if (|grant) begin
                    idx_d  = win_idx;
                    sel_d  = req_sel[win_idx];
                    data_d = win_data;
                    ptr_d  = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    if (win_data > BCD_W'(DIGIT_MAX)) begin
                        // Non-BCD addend: answer with an error, never touch the accumulator.
                        state_d     = RESP;
                        rsp_valid_d = grant;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        state_d      = ISSUE;
                        acc_add_d    = 1'b1;
                        acc_select_d = req_sel[win_idx];
                        acc_data_d   = win_data;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CNT_W'(SETTLE);
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_d     = RESP;
                    rsp_data_d  = acc_result;
                    rsp_valid_d = NUM_REQ'(1) << idx_q;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            acc_select <= 1'b0;
            acc_add    <= 1'b0;
            acc_data   <= '0;
        end else begin
            rsp_valid  <= rsp_valid_d;
            rsp_data   <= rsp_data_d;
            rsp_err    <= rsp_err_d;
            busy       <= (state_d != IDLE);
            acc_select <= acc_select_d;
            acc_add    <= acc_add_d;
            acc_data   <= acc_data_d;
        end
    end

endmodule

// File: doc/digit_acc_sched.md
Name: digit_acc_sched

Overview:
Round-robin scheduler that shares one two-digit decimal (mod-10) accumulator between NUM_REQ requesters. Each request names a digit register (0/1) and a BCD addend. The block sequences the accumulator's select/add/data_in controls, including the add pulse shape its edge detector needs, and waits SETTLE cycles. It then returns the updated digit to the requester that issued the request. It sits between the requester logic and the accumulator; only one operation is in flight at a time.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
SETTLE, 2, cycles acc_add is held low after the issue cycle before acc_result is sampled (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_sel  in  NUM_REQ  per-requester digit select, bit i belongs to requester i
req_data  in  4*NUM_REQ  per-requester BCD addend, bits [4i+3:4i]
req_ready  out  NUM_REQ  one-hot acceptance strobe
rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe
rsp_data  out  4  updated digit value, valid while any rsp_valid bit is high
rsp_err  out  1  high with rsp_valid when the request was rejected
busy  out  1  high whenever state != IDLE
acc_select  out  1  to accumulator select
acc_add  out  1  to accumulator add
acc_data  out  4  to accumulator data_in
acc_result  in  4  from accumulator data_out

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. There is one clock domain.
- Reset, including assertion mid-operation, forces:
  - state = IDLE and RR pointer = 0;
  - all outputs = 0, with acc_add dropped immediately;
  - all captured request fields = 0.
- A half-done operation is abandoned. The accumulator's own contents are not the scheduler's concern.
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - The grant goes to the first requester with req_valid=1, scanning upward from the RR pointer and wrapping at NUM_REQ-1.
  - req_ready is combinational: it is high only for the winner, and only in IDLE.
  - On valid&ready, capture the index, sel and data.
  - The pointer becomes (winner+1) mod NUM_REQ.
  - If the captured data <= 9, go to ISSUE. If data > 9, go directly to RESP with the error flag set.
- ISSUE (1 cycle): acc_add=1, acc_select=sel, acc_data=data.
- WAIT (SETTLE cycles, counted by a down-counter):
  - acc_add=0; acc_select and acc_data are held.
  - On the last WAIT cycle, register acc_result into rsp_data.
- RESP (1 cycle):
  - rsp_valid[idx]=1.
  - rsp_err=1 only on the error path; in that case rsp_data=0 and acc_add never pulsed.
  - Next state is IDLE.
- acc_select and acc_data stay at their last values in IDLE/RESP. acc_add is 1 only in ISSUE, so it always returns low between operations and every op produces a fresh rising edge.
- Timing (SETTLE=2), accept at cycle T: ISSUE T+1, WAIT T+2..T+3, RESP T+4, next accept T+5.
  - Latency is SETTLE+2 cycles from acceptance to rsp_valid.
  - Throughput is one op per SETTLE+3 cycles.
  - Error path: RESP at T+1.
- Requesters must hold req_valid/sel/data stable until req_ready. Dropping valid before acceptance is legal and removes the request.
- Simultaneous requests are served strictly round-robin: no requester waits more than NUM_REQ-1 ops.
- A requester that re-requests in its RESP cycle is not considered until IDLE.
- Width rules:
  - data is 4 bits unsigned and checked against 9 before issue.
  - The WAIT counter is $clog2(SETTLE+1) bits.
  - The index is $clog2(NUM_REQ) bits, minimum 1.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - DIGIT_MAX=9;
  - BCD_W=4.
- One sub-module is natural: rr_arbiter (parameter N).
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and grant index.
  - Purely combinational.
  - Pointer update stays in digit_acc_sched.

Test Plan:
Setup: NUM_REQ=2, SETTLE=2. The bench connects acc_* to the team's two-digit decimal accumulator, which is reset to 0.
1. req0 (sel=0, data=7) at T -> req_ready[0] at T; acc_add high only at T+1; rsp_valid[0] at T+4, rsp_data=7, rsp_err=0.
2. After 1, req0 (sel=0, data=5) -> rsp_data=2 (12 mod 10); digit 1 is untouched, confirmed by a sel=1, data=0 request returning 0.
3. req0 and req1 held valid continuously, both with sel=1, data=3 -> grants alternate 0,1,0,1, each spaced 5 cycles. Successive rsp_data values are 3,6,9,2.
4. req1 with data=12 -> rsp_valid[1] at T+1, rsp_err=1, rsp_data=0; acc_add never rises; the next valid request proceeds normally.
5. rst_n pulsed low during WAIT -> all outputs 0 asynchronously and busy=0; after release, req0 is granted first (pointer=0) and no stale rsp_valid appears.
6. req0 valid for 2 cycles then dropped while busy with req1 -> no grant to req0, no response to req0, FSM returns to IDLE.
